// File: rtl/mem_line_ctrl.sv
// Main-memory responder behind the L1 data cache: serves 128-bit line fills and
// line write-backs, one at a time, each completing after a fixed LATENCY.
//
// state   | meaning
// IDLE    | waiting for a request; write-back wins over fill
// RD_WAIT | fill accepted, counting down; line captured on terminal count
// WR_WAIT | write-back accepted, counting down; line committed on terminal count
// DONE    | one-cycle completion pulse; requests ignored
module mem_line_ctrl #(
   parameter int LATENCY    = 5,
   parameter int LINE_IDX_W = 12
) (
   input  logic         clk_i,
   input  logic         rsn_i,
   input  logic         rd_req_i,
   input  logic [19:0]  rd_addr_i,
   input  logic         wr_req_i,
   input  logic [19:0]  wr_addr_i,
   input  logic [127:0] wr_data_i,
   output logic         busy_o,
   output logic         mem_data_ready_o,
   output logic [127:0] mem_data_o,
   output logic         wr_done_o
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

   localparam int         DEPTH    = 2 ** LINE_IDX_W;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   state_t                state, state_nxt;
   logic [7:0]            cnt;
   logic                  cnt_zero;
   logic [LINE_IDX_W-1:0] idx;
   logic [127:0]          data_q;
   logic                  op_wr;
   logic                  accept_wr, accept_rd, mem_we;
   logic [127:0]          mem [DEPTH];
   logic                  unused_addr;

   // Only the line-index bits of each address are consumed.
   assign unused_addr = ^{rd_addr_i, wr_addr_i};
   assign cnt_zero    = (cnt == 8'd0);

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      accept_wr        = 1'b0;
      accept_rd        = 1'b0;
      unique case (state)
         IDLE: begin
            if (wr_req_i) begin
               accept_wr = 1'b1;
               state_nxt = WR_WAIT;
            end else if (rd_req_i) begin
               accept_rd = 1'b1;
               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: if (cnt_zero) state_nxt = DONE;
         WR_WAIT: if (cnt_zero) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_o           = (state != IDLE);
      mem_data_ready_o = (state == DONE) && !op_wr;
      wr_done_o        = (state == DONE) && op_wr;
      mem_we           = (state == WR_WAIT) && cnt_zero;
   end

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         cnt        <= 8'd0;
         idx        <= '0;
         data_q     <= '0;
         op_wr      <= 1'b0;
         mem_data_o <= '0;
      end else begin
         if (accept_wr) begin
            idx    <= wr_addr_i[LINE_IDX_W+3:4];
            data_q <= wr_data_i;
            cnt    <= CNT_LOAD;
            op_wr  <= 1'b1;
         end else if (accept_rd) begin
            idx    <= rd_addr_i[LINE_IDX_W+3:4];
            cnt    <= CNT_LOAD;
            op_wr  <= 1'b0;
         end else if ((state == RD_WAIT || state == WR_WAIT) && !cnt_zero) begin
            cnt <= cnt - 8'd1;
         end
         if (state == RD_WAIT && cnt_zero) mem_data_o <= mem[idx];
      end
   end

   // Storage is never reset; a reset forces IDLE first, so an aborted write never commits.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[idx] <= data_q;
   end
endmodule
